// File: rtl/video_timing_lock_if.sv
// Raw video timing bus from the HDMI receiver together with the lock monitor's status outputs.
interface video_timing_lock_if;
    logic        hs_i;
    logic        vs_i;
    logic        de_i;
    logic        locked_o;
    logic        frame_o;
    logic [11:0] h_active_o;
    logic [11:0] h_total_o;
    logic [11:0] v_active_o;
    logic [11:0] v_total_o;
    logic [7:0]  err_cnt_o;

    modport master (
        output hs_i, vs_i, de_i,
        input  locked_o, frame_o, h_active_o, h_total_o, v_active_o, v_total_o, err_cnt_o
    );

    modport slave (
        input  hs_i, vs_i, de_i,
        output locked_o, frame_o, h_active_o, h_total_o, v_active_o, v_total_o, err_cnt_o
    );
endinterface

// File: rtl/video_timing_lock.sv
// Measures raw hs/vs/de timing every frame and asserts locked_o after LOCK_FRAMES
// consecutive frames that match the expected video mode.
module video_timing_lock #(
    parameter int H_WIDTH     = 1920,
    parameter int H_TOTAL     = 2200,
    parameter int V_HEIGHT    = 1080,
    parameter int V_TOTAL     = 1125,
    parameter int LOCK_FRAMES = 4,
    parameter int WDOG        = 4950000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    video_timing_lock_if.slave vif
);
    localparam logic [11:0] H_WIDTH_C  = 12'(H_WIDTH);
    localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
    localparam logic [11:0] V_HEIGHT_C = 12'(V_HEIGHT);
    localparam logic [11:0] V_TOTAL_C  = 12'(V_TOTAL);
    localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
    localparam logic [22:0] WDOG_C     = 23'(WDOG);

    typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_e;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic hs_p0_q, vs_p0_q, de_p0_q;
    logic hs_prev_p0_q, vs_prev_p0_q, de_prev_p0_q;
    logic hs_rise_p1_q, vs_rise_p1_q, de_rise_p1_q, de_fall_p1_q, de_lvl_p1_q;

    // Stage p0 captures the pins, stage p1 holds the edge flags acted on one clock later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_p0_q      <= 1'b0;
            vs_p0_q      <= 1'b0;
            de_p0_q      <= 1'b0;
            hs_prev_p0_q <= 1'b0;
            vs_prev_p0_q <= 1'b0;
            de_prev_p0_q <= 1'b0;
            hs_rise_p1_q <= 1'b0;
            vs_rise_p1_q <= 1'b0;
            de_rise_p1_q <= 1'b0;
            de_fall_p1_q <= 1'b0;
            de_lvl_p1_q  <= 1'b0;
        end else begin
            hs_p0_q      <= vif.hs_i;
            vs_p0_q      <= vif.vs_i;
            de_p0_q      <= vif.de_i;
            hs_prev_p0_q <= hs_p0_q;
            vs_prev_p0_q <= vs_p0_q;
            de_prev_p0_q <= de_p0_q;
            hs_rise_p1_q <= hs_p0_q & ~hs_prev_p0_q;
            vs_rise_p1_q <= vs_p0_q & ~vs_prev_p0_q;
            de_rise_p1_q <= de_p0_q & ~de_prev_p0_q;
            de_fall_p1_q <= ~de_p0_q & de_prev_p0_q;
            de_lvl_p1_q  <= de_p0_q;
        end
    end

    state_e      state_q;
    logic [11:0] h_cnt_q, h_cnt_d, h_tot_q, h_tot_d, de_run_q, de_run_d, h_act_q, h_act_d;
    logic [11:0] v_act_q, v_act_d, v_tot_q, v_tot_d, v_act_eff, v_tot_eff;
    logic        h_valid_q, h_valid_d, line_err_q, line_err_d, line_err_eff, frame_good;

    // Same-cycle hs rise / de fall belong to the frame that a coincident vs rise closes.
    always_comb begin
        h_cnt_d      = hs_rise_p1_q ? 12'd1 : sat_inc12(h_cnt_q);
        h_tot_d      = hs_rise_p1_q ? h_cnt_q : h_tot_q;
        h_valid_d    = (state_q == HUNT) ? 1'b0 : (h_valid_q | hs_rise_p1_q);
        de_run_d     = de_rise_p1_q ? 12'd1 : (de_lvl_p1_q ? sat_inc12(de_run_q) : de_run_q);
        h_act_d      = de_fall_p1_q ? de_run_q : h_act_q;
        line_err_eff = line_err_q
                     | (hs_rise_p1_q & h_valid_q & (h_cnt_q != H_TOTAL_C))
                     | (de_fall_p1_q & (de_run_q != H_WIDTH_C));
        v_act_eff    = de_fall_p1_q ? sat_inc12(v_act_q) : v_act_q;
        v_tot_eff    = hs_rise_p1_q ? sat_inc12(v_tot_q) : v_tot_q;
        frame_good   = !line_err_eff && (v_act_eff == V_HEIGHT_C) && (v_tot_eff == V_TOTAL_C);
        v_act_d      = vs_rise_p1_q ? 12'd0 : v_act_eff;
        v_tot_d      = vs_rise_p1_q ? 12'd0 : v_tot_eff;
        line_err_d   = vs_rise_p1_q ? 1'b0 : line_err_eff;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q    <= '0;
            h_tot_q    <= '0;
            h_valid_q  <= 1'b0;
            de_run_q   <= '0;
            h_act_q    <= '0;
            v_act_q    <= '0;
            v_tot_q    <= '0;
            line_err_q <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            h_tot_q    <= h_tot_d;
            h_valid_q  <= h_valid_d;
            de_run_q   <= de_run_d;
            h_act_q    <= h_act_d;
            v_act_q    <= v_act_d;
            v_tot_q    <= v_tot_d;
            line_err_q <= line_err_d;
        end
    end

    logic [3:0]  good_cnt_q;
    logic [22:0] wd_q;
    logic        locked_q, frame_q;
    logic [11:0] v_active_q, v_total_q;
    logic [7:0]  err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            good_cnt_q <= '0;
            wd_q       <= '0;
            locked_q   <= 1'b0;
            frame_q    <= 1'b0;
            v_active_q <= '0;
            v_total_q  <= '0;
            err_q      <= '0;
        end else begin
            frame_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    // The partial frame seen while hunting is discarded, not evaluated.
                    wd_q       <= '0;
                    good_cnt_q <= '0;
                    locked_q   <= 1'b0;
                    if (vs_rise_p1_q) state_q <= CHECK;
                end
                CHECK, LOCKED: begin
                    if (vs_rise_p1_q) begin
                        wd_q       <= '0;
                        frame_q    <= 1'b1;
                        v_active_q <= v_act_eff;
                        v_total_q  <= v_tot_eff;
                        if (frame_good) begin
                            if (state_q == CHECK) begin
                                good_cnt_q <= good_cnt_q + 4'd1;
                                if (good_cnt_q + 4'd1 == LOCK_C) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end
                        end else begin
                            state_q    <= CHECK;
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            err_q      <= sat_inc8(err_q);
                        end
                    end else if (wd_q + 23'd1 == WDOG_C) begin
                        state_q    <= HUNT;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                        wd_q       <= '0;
                        err_q      <= sat_inc8(err_q);
                    end else begin
                        wd_q <= wd_q + 23'd1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign vif.locked_o   = locked_q;
    assign vif.frame_o    = frame_q;
    assign vif.h_active_o = h_act_q;
    assign vif.h_total_o  = h_tot_q;
    assign vif.v_active_o = v_active_q;
    assign vif.v_total_o  = v_total_q;
    assign vif.err_cnt_o  = err_q;
endmodule

// File: doc/video_timing_lock.md
Name: video_timing_lock

Overview:
- Sits directly downstream of the HDMI receiver, on the vin_hs/vin_vs/vin_de bus, alongside the fantasy and delayer stages.
- Measures incoming raw video timing every frame and compares it against the expected mode parameters.
- Asserts locked_o only after LOCK_FRAMES consecutive conforming frames. Downstream stages use locked_o to gate processing and DDR writes.
- Exports the measured timing and an error counter for LED/debug monitoring.

Parameters:
H_WIDTH, 1920, expected active pixels per line (de high run length)
H_TOTAL, 2200, expected clocks between hs rising edges
V_HEIGHT, 1080, expected active lines per frame
V_TOTAL, 1125, expected hs rising edges per frame
LOCK_FRAMES, 4, consecutive good frames required to lock (1..15)
WDOG, 4950000, clocks without vs rising edge before fall back to HUNT (23-bit counter)

Ports:
clk_i  in  1  pixel clock (vin_clk)
rst_i  in  1  synchronous active-high reset
hs_i  in  1  hsync, positive polarity
vs_i  in  1  vsync, positive polarity
de_i  in  1  data enable
locked_o  out  1  timing conforms; stable for LOCK_FRAMES frames
frame_o  out  1  one-cycle pulse at each evaluated frame boundary
h_active_o  out  12  last captured de run length
h_total_o  out  12  last captured line period
v_active_o  out  12  active lines in last frame
v_total_o  out  12  hs edges in last frame
err_cnt_o  out  8  bad frames plus watchdog timeouts, saturating at 255

Behaviour:
- Input stage: hs/vs/de are registered once. Rising/falling edges are detected from the registered value vs the previous registered value. All outputs are registered.
- Latency: an edge first sampled at clock edge N is acted on at edge N+2. For vs, frame_o, locked_o and the *_o measurements all update at N+2.
- h_cnt:
  - Cleared to 1 on hs rise, else increments; saturates at 4095.
  - On hs rise, h_total_o <= h_cnt value before the clear.
  - If that value != H_TOTAL, set sticky line_err.
- de_run:
  - Counts de-high cycles; cleared on de rise.
  - On de fall, h_active_o <= de_run and v_act_cnt increments.
  - If de_run != H_WIDTH, set line_err.
- v_tot_cnt increments on each hs rise.
- Same-cycle events: an hs rise or de fall on the same cycle as a vs rise is counted into the ending frame, then the frame is evaluated.
- Frame boundary (vs rise):
  - v_active_o <= v_act_cnt; v_total_o <= v_tot_cnt.
  - good = !line_err && v_act_cnt == V_HEIGHT && v_tot_cnt == V_TOTAL.
  - Then v_act_cnt, v_tot_cnt and line_err are cleared and the watchdog is cleared.
  - frame_o pulses in states CHECK and LOCKED only.
- The first hs period after HUNT (h_cnt invalid) is not checked.
- FSM:
  - HUNT (reset state): locked_o=0, good_cnt=0. On vs rise, clear all frame counters and go to CHECK; no evaluation and no frame_o, because the partial frame is discarded.
  - CHECK:
    - good frame: good_cnt++; when good_cnt reaches LOCK_FRAMES, go to LOCKED (locked_o=1 at the same edge).
    - bad frame: good_cnt=0, err_cnt++, stay in CHECK.
  - LOCKED:
    - good frame: stay.
    - bad frame: go to CHECK, locked_o=0, good_cnt=0, err_cnt++.
  - Watchdog: in CHECK/LOCKED, reaching WDOG clocks since the last vs rise forces HUNT, locked_o=0, err_cnt++. The watchdog is idle in HUNT.
- err_cnt_o saturates at 255 and never wraps.
- Reset at any time, including mid-frame:
  - All outputs are 0; the FSM goes to HUNT; all counters are 0.
  - The input registers are cleared to 0, so a signal held high across reset reads as a rising edge after reset.

Test Plan:
(Bench parameters: H_WIDTH=8, H_TOTAL=12, V_HEIGHT=4, V_TOTAL=6, LOCK_FRAMES=3, WDOG=200.)
1. Reset, then 4 conforming frames (6 lines × 12 clocks, 4 lines with 8-clock de) -> frame_o pulses 3 times; locked_o=1 at the 3rd evaluated boundary; h_active_o=8, h_total_o=12, v_active_o=4, v_total_o=6, err_cnt_o=0.
2. While locked, one frame has a line with a 7-clock de -> at that boundary locked_o=0, err_cnt_o=1. Three further good frames relock.
3. While locked, vs is held low for 200 clocks -> locked_o=0, FSM in HUNT, err_cnt_o increments by 1; the next vs rise produces no frame_o.
4. Frame with v_total=7 (extra blank line) -> v_total_o=7, not locked, good_cnt reset. Lock still needs 3 subsequent good frames.
5. 300 consecutive bad frames -> err_cnt_o stops at 255.
6. rst_i asserted mid-frame while locked -> the next edge gives all outputs 0. The first post-reset vs rise is discarded; lock is reached after 3 further good frames.
